// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared encodings and defaults for the two-requester ALU arbiter
package alu_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_OPW   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, combinational, one-hot output
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      grant[prio] = 1'b1;
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external combinational ALU between requesters A and B
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [WIDTH-1:0] a_op_a,
  input  logic [WIDTH-1:0] a_op_b,
  input  logic [OPW-1:0]   a_op,
  input  logic             a_unsig,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic [WIDTH-1:0] a_rsp_data,
  output logic             a_rsp_compout,
  output logic             a_rsp_overflow,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [WIDTH-1:0] b_op_a,
  input  logic [WIDTH-1:0] b_op_b,
  input  logic [OPW-1:0]   b_op,
  input  logic             b_unsig,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [WIDTH-1:0] b_rsp_data,
  output logic             b_rsp_compout,
  output logic             b_rsp_overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_unsig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compout,
  input  logic             alu_overflow,
  output logic             busy
);

  state_t     state;
  state_t     state_next;
  logic       prio;
  logic       gid;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       accept_a;
  logic       accept_b;

  // A requester holding an undelivered response is not eligible, so a capture never overwrites one.
  assign elig = {b_req_valid & ~b_rsp_valid, a_req_valid & ~a_rsp_valid};

  rr_arbiter2 u_rr (
    .elig  (elig),
    .prio  (prio),
    .grant (grant)
  );

  assign a_req_ready = (state == IDLE) & grant[0];
  assign b_req_ready = (state == IDLE) & grant[1];
  assign accept_a    = a_req_valid & a_req_ready;
  assign accept_b    = b_req_valid & b_req_ready;
  assign busy        = (state == EXEC);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_a || accept_b) state_next = EXEC;
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio           <= REQ_A;
      gid            <= REQ_A;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_unsig      <= 1'b0;
      a_rsp_valid    <= 1'b0;
      a_rsp_data     <= '0;
      a_rsp_compout  <= 1'b0;
      a_rsp_overflow <= 1'b0;
      b_rsp_valid    <= 1'b0;
      b_rsp_data     <= '0;
      b_rsp_compout  <= 1'b0;
      b_rsp_overflow <= 1'b0;
    end else begin
      if (accept_a || accept_b) begin
        alu_a     <= accept_b ? b_op_a  : a_op_a;
        alu_b     <= accept_b ? b_op_b  : a_op_b;
        alu_op    <= accept_b ? b_op    : a_op;
        alu_unsig <= accept_b ? b_unsig : a_unsig;
        gid       <= accept_b ? REQ_B : REQ_A;
        prio      <= accept_b ? REQ_A : REQ_B;
      end
      if (a_rsp_valid && a_rsp_ready) a_rsp_valid <= 1'b0;
      if (b_rsp_valid && b_rsp_ready) b_rsp_valid <= 1'b0;
      if (state == EXEC) begin
        if (gid == REQ_A) begin
          a_rsp_valid    <= 1'b1;
          a_rsp_data     <= alu_out;
          a_rsp_compout  <= alu_compout;
          a_rsp_overflow <= alu_overflow;
        end else begin
          b_rsp_valid    <= 1'b1;
          b_rsp_data     <= alu_out;
          b_rsp_compout  <= alu_compout;
          b_rsp_overflow <= alu_overflow;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an adder stub ALU
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req_valid, a_req_ready, a_unsig, a_rsp_valid, a_rsp_ready;
  logic             a_rsp_compout, a_rsp_overflow;
  logic [WIDTH-1:0] a_op_a, a_op_b, a_rsp_data;
  logic [OPW-1:0]   a_op;
  logic             b_req_valid, b_req_ready, b_unsig, b_rsp_valid, b_rsp_ready;
  logic             b_rsp_compout, b_rsp_overflow;
  logic [WIDTH-1:0] b_op_a, b_op_b, b_rsp_data;
  logic [OPW-1:0]   b_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_unsig, alu_compout, alu_overflow, busy;
  logic [WIDTH:0]   alu_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out      = alu_sum[WIDTH-1:0];
  assign alu_overflow = alu_sum[WIDTH];
  assign alu_compout  = (alu_a < alu_b);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op_a(a_op_a), .a_op_b(a_op_b),
    .a_op(a_op), .a_unsig(a_unsig), .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_rsp_data(a_rsp_data), .a_rsp_compout(a_rsp_compout), .a_rsp_overflow(a_rsp_overflow),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op_a(b_op_a), .b_op_b(b_op_b),
    .b_op(b_op), .b_unsig(b_unsig), .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_rsp_data(b_rsp_data), .b_rsp_compout(b_rsp_compout), .b_rsp_overflow(b_rsp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
    .alu_out(alu_out), .alu_compout(alu_compout), .alu_overflow(alu_overflow), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {overflow, compout, data} for the adder stub.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {s[32], (x < y), s[31:0]};
  endfunction

  logic [33:0] qa[$];
  logic [33:0] qb[$];
  logic [33:0] ea, eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_req_valid && a_req_ready) qa.push_back(model(a_op_a, a_op_b));
      if (b_req_valid && b_req_ready) qb.push_back(model(b_op_a, b_op_b));
      if (a_rsp_valid && a_rsp_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_a_unexpected: got response 0x%0h, expected none", a_rsp_data);
        end else begin
          ea = qa.pop_front();
          check("sb_a", {30'd0, a_rsp_overflow, a_rsp_compout, a_rsp_data}, {30'd0, ea});
        end
      end
      if (b_rsp_valid && b_rsp_ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_b_unexpected: got response 0x%0h, expected none", b_rsp_data);
        end else begin
          eb = qb.pop_front();
          check("sb_b", {30'd0, b_rsp_overflow, b_rsp_compout, b_rsp_data}, {30'd0, eb});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    check("rst_b_rsp_valid", b_rsp_valid, 0);
    check("rst_rsp_data", {a_rsp_data, b_rsp_data}, 0);
    check("rst_flags", {a_rsp_compout, a_rsp_overflow, b_rsp_compout, b_rsp_overflow}, 0);
    check("rst_alu_regs", {alu_a, alu_b}, 0);
    check("rst_alu_op", {alu_op, alu_unsig, busy}, 0);
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
    logic [31:0] data;
    logic        comp;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] got, exp2;

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 3'b010, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 3'b111, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 3'b101, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 3'b011, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b110, 1'b1, 32'h0000_0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    a_req_valid = 0; a_op_a = 0; a_op_b = 0; a_op = 0; a_unsig = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_op_a = 0; b_op_b = 0; b_op = 0; b_unsig = 0; b_rsp_ready = 1;
    tick();
    do_reset();

    // Single requests from A: accept at T, operands on the ALU at T+1, response at T+2.
    for (int i = 0; i < 6; i++) begin
      a_req_valid = 1; a_op_a = vecs[i].a; a_op_b = vecs[i].b; a_op = vecs[i].op; a_unsig = vecs[i].unsig;
      @(negedge clk);
      check($sformatf("v%0d_req_ready", i), a_req_ready, 1);
      tick();
      a_req_valid = 0;
      @(negedge clk);
      check($sformatf("v%0d_alu_ab", i), {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
      check($sformatf("v%0d_alu_op", i), {alu_op, alu_unsig, busy}, {vecs[i].op, vecs[i].unsig, 1'b1});
      check($sformatf("v%0d_rsp_early", i), a_rsp_valid, 0);
      tick();
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid", i), a_rsp_valid, 1);
      check($sformatf("v%0d_rsp", i), {a_rsp_data, a_rsp_compout, a_rsp_overflow},
            {vecs[i].data, vecs[i].comp, vecs[i].ovf});
      tick();
    end

    // Contention: both valid from reset release, responses drained at once.
    a_req_valid = 1; a_op_a = 32'd10; a_op_b = 32'd20;
    b_req_valid = 1; b_op_a = 32'd100; b_op_b = 32'd7;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got  = {b_req_valid & b_req_ready, a_req_valid & a_req_ready};
      exp2 = (i % 2 != 0) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_cycle%0d", i), got, exp2);
      tick();
    end
    a_req_valid = 0; b_req_valid = 0;
    repeat (3) tick();

    // Backpressure on A while B is served.
    a_req_valid = 1; a_op_a = 32'd7; a_op_b = 32'd9; a_rsp_ready = 0;
    do_reset();
    @(negedge clk);
    check("bp_a_accept", a_req_ready, 1);
    tick();
    tick();
    b_req_valid = 1; b_op_a = 32'd1; b_op_b = 32'd2;
    @(negedge clk);
    check("bp_a_rsp", {a_rsp_valid, a_rsp_data}, {1'b1, 32'd16});
    check("bp_b_accept", b_req_ready, 1);
    tick();
    b_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {a_req_ready, a_rsp_valid, a_rsp_data}, {1'b0, 1'b1, 32'd16});
      if (i == 1) check("bp_b_rsp", {b_rsp_valid, b_rsp_data}, {1'b1, 32'd3});
      tick();
    end
    a_rsp_ready = 1;
    @(negedge clk);
    check("bp_release", a_rsp_valid, 1);
    tick();
    @(negedge clk);
    check("bp_reaccept", {a_rsp_valid, a_req_ready}, 2'b01);
    tick();
    a_req_valid = 0;
    repeat (3) tick();

    // Reset during EXEC discards the op; A wins the first post-reset grant.
    a_req_valid = 1; a_op_a = 32'h55; a_op_b = 32'h22;
    do_reset();
    @(negedge clk);
    check("re_accept", a_req_ready, 1);
    tick();
    rst_n = 0;
    @(negedge clk);
    check("re_in_exec", busy, 1);
    tick();
    rst_n = 1;
    b_req_valid = 1; b_op_a = 32'h3; b_op_b = 32'h4;
    @(negedge clk);
    check("re_cleared", {a_rsp_valid, b_rsp_valid, busy, alu_a, a_rsp_data}, 0);
    check("re_grant", {b_req_ready, a_req_ready}, 2'b01);
    tick();
    a_req_valid = 0;
    @(negedge clk);
    check("re_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    tick();
    b_req_valid = 0;
    repeat (6) tick();

    @(negedge clk);
    check("sb_drained", qa.size() + qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
